// File: rtl/hs_unit_pkg.sv
// Shared types for the handshake utility blocks.
// The skid-buffer occupancy encoding is used by the slice RTL and its bench.
package hs_unit_pkg;

    typedef enum logic [1:0] {
        HS_SKID_EMPTY = 2'd0,
        HS_SKID_BUSY  = 2'd1,
        HS_SKID_FULL  = 2'd2
    } hs_skid_state_e;

endpackage

// File: rtl/hs_unit_skid_buf.sv
// Fully-registered valid/ready slice with a two-entry skid buffer.
// All outputs come from flops, so both the forward and ready paths are cut.
module hs_unit_skid_buf
    import hs_unit_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     aresetn,
    input  logic     s_valid,
    output logic     s_ready,
    input  DATA_TYPE s_data,
    output logic     m_valid,
    input  logic     m_ready,
    output DATA_TYPE m_data
);

    hs_skid_state_e r_state;
    hs_skid_state_e w_state_next;
    DATA_TYPE       r_main;
    DATA_TYPE       r_skid;
    logic           r_s_ready;
    logic           w_s_fire;
    logic           w_m_fire;

    assign m_valid  = (r_state != HS_SKID_EMPTY);
    assign m_data   = r_main;
    assign s_ready  = r_s_ready;
    assign w_s_fire = s_valid & r_s_ready;
    assign w_m_fire = m_valid & m_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HS_SKID_EMPTY: if (w_s_fire) w_state_next = HS_SKID_BUSY;
            HS_SKID_BUSY: begin
                if (w_s_fire && !m_ready)      w_state_next = HS_SKID_FULL;
                else if (!w_s_fire && w_m_fire) w_state_next = HS_SKID_EMPTY;
            end
            HS_SKID_FULL:  if (m_ready) w_state_next = HS_SKID_BUSY;
            default:       w_state_next = HS_SKID_EMPTY;
        endcase
    end

    // s_ready leaves reset low and rises on the first edge after release.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= HS_SKID_EMPTY;
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_s_ready <= (w_state_next != HS_SKID_FULL);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_main <= RESET_VALUE;
        end else if (r_state == HS_SKID_FULL) begin
            if (m_ready) r_main <= r_skid;
        end else if (w_s_fire && (r_state == HS_SKID_EMPTY || m_ready)) begin
            r_main <= s_data;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_skid <= RESET_VALUE;
        end else if (r_state == HS_SKID_BUSY && w_s_fire && !m_ready) begin
            r_skid <= s_data;
        end
    end

`ifndef SYNTHESIS
    // A stalled output must stay valid with unchanged data on the next cycle.
    logic     r_chk_stall;
    DATA_TYPE r_chk_data;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_chk_stall <= 1'b0;
            r_chk_data  <= RESET_VALUE;
        end else begin
            if (r_chk_stall) begin
                a_hold: assert (m_valid && (m_data == r_chk_data));
            end
            a_state: assert (r_state inside {HS_SKID_EMPTY, HS_SKID_BUSY, HS_SKID_FULL});
            r_chk_stall <= m_valid & ~m_ready;
            r_chk_data  <= m_data;
        end
    end
`endif

endmodule
